ula_seq: RTL and testbench
==========================

// Module: ula_seq
// PURPOSE
//  Parametrised, clocked successor of the combinational 16-bit add/sub ULA.
//  Registers operands and results, and widens the op set to eight operations.
//  Handles MUL/DIV iteratively over WIDTH cycles.
//  Sits between the register file and the writeback mux; the control unit issues ops
//  via a start/ready/done handshake.
// PARAMETERS
//  WIDTH   16  operand/result width in bits (>=4)
//  CNT_W   $clog2(WIDTH+1)  iteration counter width (derived, do not override)
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      issue request; sampled only when ready=1
//  op_sel      in   3      operation code (see BEHAVIOUR)
//  in_a        in   WIDTH  operand A, latched on accepted start
//  in_b        in   WIDTH  operand B, latched on accepted start
//  ready       out  1      block can accept start (state IDLE or DONE)
//  busy        out  1      iterative op in progress (state EXEC)
//  done        out  1      one-cycle pulse: result/flags valid and updated
//  result      out  WIDTH  primary result
//  result_hi   out  WIDTH  MUL: upper product half; DIV: remainder; else 0
//  flag_zero   out  1      result == 0
//  flag_carry  out  1      ADD carry-out; SUB no-borrow (a>=b unsigned); else 0
//  flag_ovf    out  1      signed overflow for ADD/SUB; else 0
//  flag_divz   out  1      DIV with in_b == 0; else 0
// BEHAVIOUR
//  - op_sel: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 0/1),
//    110 MUL (unsigned, 2*WIDTH product), 111 DIV (unsigned restoring).
//  - FSM states: IDLE, EXEC, DONE. Reset -> IDLE. All outputs 0 except ready=1.
//  - Accept: start=1 while ready=1 latches op_sel/in_a/in_b. start while busy is ignored
//    (not queued).
//  - Single-cycle ops (000-101): IDLE/DONE -> DONE. done=1 on the clock after the
//    accepting edge; latency 1.
//  - MUL/DIV: IDLE/DONE -> EXEC, counter=WIDTH. Each EXEC cycle does one shift-add or
//    restoring-subtract step and decrements the counter. Counter==1 -> DONE.
//    busy=1 for exactly WIDTH cycles. done=1 exactly WIDTH+1 clocks after the accept.
//  - DONE lasts one cycle, then IDLE. A start in DONE is accepted, allowing back-to-back
//    issue with no bubble.
//  - result/result_hi/flags update only on entry to DONE and hold until the next DONE.
//    Flags are never valid mid-EXEC.
//  - Arithmetic is modulo 2^WIDTH. ADD/SUB overflow = operand sign rule on the
//    WIDTH-bit result.
//  - DIV by 0: no iteration is skipped (latency unchanged). Outputs result=all-ones,
//    result_hi=in_a, flag_divz=1.
//  - MUL: flag_zero reflects result (low half) only.
//  - rst=1 in any state, including mid-EXEC: next cycle is IDLE with all outputs
//    cleared. The partial op is discarded. rst has priority over start.
// STRUCTURE
//  - Shared header ula_defs: op_sel encodings (OP_ADD..OP_DIV) and FSM state encodings.
//    Also used by the control unit.
//  - Sub-module ula_muldiv_iter: iterative shift-add multiplier / restoring divider core.
//    Interface is load, step, mode, and the acc/quot/rem registers.
//  - Top holds the FSM, operand latches, single-cycle datapath, flag logic and output
//    registers.
// TESTING (WIDTH=16)
//  - ADD 0x0001+0x0003 -> result 0x0004, done 1 clk after accept, all flags 0.
//  - ADD 0xFFFF+0xFFFF -> 0xFFFE, carry=1, ovf=0.
//  - SUB 0x8000-0x0001 -> 0x7FFF, carry=1, ovf=1.
//  - SLT 0xFFFF vs 0x0001 -> 0x0001.
//  - MUL 0x1234*0x0010 -> result 0x2340, result_hi 0x0001; busy for 16 clks;
//    done exactly 17 clks after accept.
//  - DIV 100/7 -> result 14, result_hi 2, divz=0.
//  - DIV 0x00AB/0 -> result 0xFFFF, result_hi 0x00AB, divz=1, still 17-clk latency.
//  - Start ADD during MUL busy -> ignored, MUL result unchanged.
//  - rst at EXEC cycle 5 -> next clk busy=0, done=0, result=0, ready=1.
//    A following AND 0xF0F0&0x0FF0 -> 0x00F0.
//  - Back-to-back: start asserted in DONE of a MUL -> accepted, no idle cycle between ops.

Source files
------------

// File: rtl/ula_seq_pkg.sv
// Shared ULA definitions: operation codes, FSM state encodings and the flag bundle.
// The control unit imports the same package so both sides agree on the encodings.
package ula_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_DIV = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic divz;
    } flags_t;

    function automatic logic is_iterative(input op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ula_seq_muldiv_iter.sv
// Iterative core: one shift-add multiply step or one restoring-divide step per cycle.
// The step_* outputs show the register contents after the step being taken this cycle.
module ula_muldiv_iter
    import ula_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  md_mode_e         mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] step_hi_o,
    output logic [WIDTH-1:0] step_lo_o
);

    // hi holds the upper product half / remainder, lo the multiplier / quotient.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q;
    md_mode_e         mode_q;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        if (mode_q == MD_MUL) begin
            sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
            shifted = {hi_q, lo_q[WIDTH-1]};
            diff    = shifted - {1'b0, b_q};
            // Top bit of diff set means the trial subtraction borrowed: restore.
            if (!diff[WIDTH]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign step_hi_o = hi_d;
    assign step_lo_o = lo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            mode_q <= MD_MUL;
        end else if (load_i) begin
            hi_q   <= '0;
            lo_q   <= a_i;
            b_q    <= b_i;
            mode_q <= mode_i;
        end else if (step_i) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Clocked ULA: single-cycle ALU ops plus iterative MUL/DIV behind a start/ready/done handshake.
// Results and flags are registered and only change on entry to DONE.
module ula_seq
    import ula_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op_sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_divz,
    output state_e           state_dbg
);

    // Handshake: a start is taken only on a rising edge where ready=1 (IDLE or DONE);
    // starts presented while busy are dropped, and done pulses for one cycle per op.
    state_e           state_q, state_d;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    flags_t           flags_q, flags_d;

    op_e              op_in;
    logic             accept;
    logic             core_load;
    logic             core_step;
    md_mode_e         core_mode;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] sc_result;
    flags_t           sc_flags;

    assign op_in     = op_e'(op_sel);
    assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy      = (state_q == ST_EXEC);
    assign done      = (state_q == ST_DONE);
    assign accept    = start && ready;
    assign core_mode = (op_in == OP_DIV) ? MD_DIV : MD_MUL;

    assign result     = result_q;
    assign result_hi  = result_hi_q;
    assign flag_zero  = flags_q.zero;
    assign flag_carry = flags_q.carry;
    assign flag_ovf   = flags_q.ovf;
    assign flag_divz  = flags_q.divz;
    assign state_dbg  = state_q;

    assign add_full = {1'b0, in_a} + {1'b0, in_b};
    assign sub_full = {1'b0, in_a} - {1'b0, in_b};

    always_comb begin
        sc_result = '0;
        sc_flags  = '0;
        unique case (op_in)
            OP_ADD: begin
                sc_result      = add_full[WIDTH-1:0];
                sc_flags.carry = add_full[WIDTH];
                sc_flags.ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                                 (add_full[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result      = sub_full[WIDTH-1:0];
                // Carry on SUB means no borrow, i.e. a >= b unsigned.
                sc_flags.carry = !sub_full[WIDTH];
                sc_flags.ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                                 (sub_full[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND: sc_result = in_a & in_b;
            OP_OR:  sc_result = in_a | in_b;
            OP_XOR: sc_result = in_a ^ in_b;
            OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            default: sc_result = '0;
        endcase
        sc_flags.zero = (sc_result == '0);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        core_load   = 1'b0;
        core_step   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (is_iterative(op_in)) begin
                        state_d   = ST_EXEC;
                        cnt_d     = CNT_W'(WIDTH);
                        core_load = 1'b1;
                    end else begin
                        state_d     = ST_DONE;
                        result_d    = sc_result;
                        result_hi_d = '0;
                        flags_d     = sc_flags;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                core_step = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    flags_d = '0;
                    if ((op_q == OP_DIV) && (b_q == '0)) begin
                        result_d     = '1;
                        result_hi_d  = a_q;
                        flags_d.divz = 1'b1;
                    end else begin
                        result_d    = step_lo;
                        result_hi_d = step_hi;
                    end
                    flags_d.zero = (result_d == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            if (accept) begin
                op_q <= op_in;
                a_q  <= in_a;
                b_q  <= in_b;
            end
        end
    end

    ula_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .load_i   (core_load),
        .step_i   (core_step),
        .mode_i   (core_mode),
        .a_i      (in_a),
        .b_i      (in_b),
        .step_hi_o(step_hi),
        .step_lo_o(step_lo)
    );

endmodule

// File: tb/tb_ula_seq.sv
// Directed and randomized bench for ula_seq at WIDTH=16 against an arithmetic reference model.
module tb_ula_seq;
    import ula_seq_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op_sel;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         flag_zero;
    logic         flag_carry;
    logic         flag_ovf;
    logic         flag_divz;
    state_e       state_dbg;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ula_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sel    (op_sel),
        .in_a      (in_a),
        .in_b      (in_b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flag_zero (flag_zero),
        .flag_carry(flag_carry),
        .flag_ovf  (flag_ovf),
        .flag_divz (flag_divz),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the operation definitions, using wide integer arithmetic.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [W-1:0] hi,
                         output logic z, output logic c, output logic v, output logic dz);
        longint ua, ub, sa, sb, t;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t  = 0;
        r  = '0;
        hi = '0;
        c  = 1'b0;
        v  = 1'b0;
        dz = 1'b0;
        case (op)
            OP_ADD: begin
                t = ua + ub;
                r = t[W-1:0];
                c = (t >= 65536);
                v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            OP_SUB: begin
                t = ua - ub;
                r = t[W-1:0];
                c = (ua >= ub);
                v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SLT: r = (sa < sb) ? 16'd1 : 16'd0;
            OP_MUL: begin
                t  = ua * ub;
                r  = t[15:0];
                hi = t[31:16];
            end
            default: begin
                if (ub == 0) begin
                    r  = 16'hFFFF;
                    hi = a;
                    dz = 1'b1;
                end else begin
                    t  = ua / ub;
                    r  = t[W-1:0];
                    t  = ua % ub;
                    hi = t[W-1:0];
                end
            end
        endcase
        z = (r == '0);
    endtask

    // Called just after a falling edge; start is taken on the next rising edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        op_sel = op;
        in_a   = a;
        in_b   = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts falling edges until done; optionally presents a stray ADD start at cycle 'intrude'.
    task automatic wait_done(input int intrude, output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (done || lat >= 40) break;
            if (lat == intrude) begin
                start  = 1'b1;
                op_sel = OP_ADD;
                in_a   = 16'h1111;
                in_b   = 16'h2222;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er, eh;
        logic ez, ec, ev, edz;
        model(op, a, b, er, eh, ez, ec, ev, edz);
        check({tag, "_done"},   32'(done),       32'd1);
        check({tag, "_result"}, 32'(result),     32'(er));
        check({tag, "_hi"},     32'(result_hi),  32'(eh));
        check({tag, "_zero"},   32'(flag_zero),  32'(ez));
        check({tag, "_carry"},  32'(flag_carry), 32'(ec));
        check({tag, "_ovf"},    32'(flag_ovf),   32'(ev));
        check({tag, "_divz"},   32'(flag_divz),  32'(edz));
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int intrude);
        int  lat, nbusy;
        bit  iter;
        iter = (op == OP_MUL) || (op == OP_DIV);
        issue(op, a, b);
        wait_done(intrude, lat, nbusy);
        check({tag, "_latency"}, 32'(lat),   iter ? 32'(W + 1) : 32'd1);
        check({tag, "_busy"},    32'(nbusy), iter ? 32'(W) : 32'd0);
        check_outputs(tag, op, a, b);
    endtask

    initial begin
        int lat, nbusy;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;

        rst    = 1'b1;
        start  = 1'b0;
        op_sel = '0;
        in_a   = '0;
        in_b   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",  32'(ready),     32'd1);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_done",   32'(done),      32'd0);
        check("rst_result", 32'(result),    32'd0);
        check("rst_hi",     32'(result_hi), 32'd0);
        check("rst_flags",  32'({flag_zero, flag_carry, flag_ovf, flag_divz}), 32'd0);
        check("rst_state",  32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;

        run_op("add_small", OP_ADD, 16'h0001, 16'h0003, 0);
        check("add_small_const", 32'(result), 32'h0004);
        @(negedge clk);
        check("hold_done",   32'(done),      32'd0);
        check("hold_result", 32'(result),    32'h0004);
        check("hold_ready",  32'(ready),     32'd1);
        check("hold_state",  32'(state_dbg), 32'(ST_IDLE));

        run_op("add_wrap", OP_ADD, 16'hFFFF, 16'hFFFF, 0);
        check("add_wrap_const", 32'({result, flag_carry, flag_ovf}), {16'h0, 16'hFFFE, 1'b1, 1'b0} >> 0 & 32'h3FFFF);
        run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 0);
        check("sub_ovf_const", 32'({result, flag_carry, flag_ovf}), 32'({16'h7FFF, 2'b11}));
        run_op("slt_neg", OP_SLT, 16'hFFFF, 16'h0001, 0);
        check("slt_neg_const", 32'(result), 32'h0001);
        run_op("sub_borrow", OP_SUB, 16'h0001, 16'h0002, 0);
        run_op("xor_zero", OP_XOR, 16'hA5A5, 16'hA5A5, 0);

        run_op("mul", OP_MUL, 16'h1234, 16'h0010, 0);
        check("mul_const", 32'({result_hi, result}), 32'h0001_2340);
        check("b2b_ready", 32'(ready), 32'd1);
        // Back-to-back: issue from the DONE cycle; the next cycle must already be EXEC.
        issue(OP_MUL, 16'h0003, 16'h0005);
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done", 32'(done), 32'd0);
        wait_done(0, lat, nbusy);
        check("b2b_latency", 32'(lat + 1),   32'(W + 1));
        check("b2b_nbusy",   32'(nbusy + 1), 32'(W));
        check_outputs("b2b", OP_MUL, 16'h0003, 16'h0005);

        run_op("div", OP_DIV, 16'd100, 16'd7, 0);
        check("div_const", 32'({result_hi, result, flag_divz}), 32'({16'd2, 16'd14, 1'b0}));
        run_op("div0", OP_DIV, 16'h00AB, 16'h0000, 0);
        check("div0_const", 32'({result_hi, result, flag_divz}), 32'({16'h00AB, 16'hFFFF, 1'b1}));
        run_op("mul_ignore", OP_MUL, 16'h00FF, 16'h0101, 3);

        issue(OP_MUL, 16'h7777, 16'h0003);
        repeat (5) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_busy",   32'(busy),      32'd0);
        check("mrst_done",   32'(done),      32'd0);
        check("mrst_result", 32'(result),    32'd0);
        check("mrst_hi",     32'(result_hi), 32'd0);
        check("mrst_ready",  32'(ready),     32'd1);
        run_op("and_after_rst", OP_AND, 16'hF0F0, 16'h0FF0, 0);
        check("and_const", 32'(result), 32'h00F0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            run_op("rnd", rop, ra, rb, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
